pc_fetch_stage: RTL and testbench

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

---
 rtl/pc_fetch_stage_if.sv | 46 ++++
 rtl/pc_fetch_stage.sv | 158 +++++++++++++++
 tb/tb_pc_fetch_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_stage_if.sv
// pc_fetch_stage_if -- fetch-stage bus: pipeline control, instruction memory
// port and IF/ID register outputs.
// Optional feature macro: PC_MISALIGN_TRAP_EN adds the misalign_o trap pulse.
// The master modport is the fetch stage. The slave modport is the surrounding
// pipeline and the instruction memory.
interface pc_fetch_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall_i;
  logic              flush_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_addr_i;
  logic              halt_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_i;
  logic              ifid_valid_o;
  logic [ADDR_W-1:0] ifid_pc_o;
  logic [ADDR_W-1:0] ifid_pc4_o;
  logic [31:0]       ifid_instr_o;
  logic              halted_o;
`ifdef PC_MISALIGN_TRAP_EN
  logic              misalign_o;

  modport master (
    input  stall_i, flush_i, redirect_i, redirect_addr_i, halt_i, imem_data_i,
    output imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o,
           halted_o, misalign_o
  );
  modport slave (
    output stall_i, flush_i, redirect_i, redirect_addr_i, halt_i, imem_data_i,
    input  imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o,
           halted_o, misalign_o
  );
`else
  modport master (
    input  stall_i, flush_i, redirect_i, redirect_addr_i, halt_i, imem_data_i,
    output imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o,
           halted_o
  );
  modport slave (
    output stall_i, flush_i, redirect_i, redirect_addr_i, halt_i, imem_data_i,
    input  imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o,
           halted_o
  );
`endif
endinterface

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage -- program counter, instruction fetch and IF/ID register.
// The BOOT/RUN/HALT FSM sequences the PC. The imem address is the PC register.
// The IF/ID register latches the instruction one cycle after it is fetched.
// Optional feature macro: PC_MISALIGN_TRAP_EN. When it is defined, a redirect
// to an address that is not a multiple of INSTR_BYTES is sent to TRAP_VEC
// instead, and misalign_o pulses for one cycle.
module pc_fetch_stage #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = {ADDR_W{1'b0}},
  parameter int unsigned       INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0] TRAP_VEC    = ADDR_W'(32'h80)
) (
  input logic               clk,
  input logic               rst_n,
  pc_fetch_stage_if.master  bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(INSTR_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [ADDR_W-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0]       ifid_instr_q, ifid_instr_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] pc_inc_s;
  logic              mis_s;
  logic [ADDR_W-1:0] target_s;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
  logic              misalign_q, misalign_d;
`endif

  // Sequential increment wraps naturally modulo 2^ADDR_W.
  assign pc_inc_s = pc_q + INC;

  // The redirect target, replaced by the trap vector when it is misaligned.
  always_comb begin
`ifdef PC_MISALIGN_TRAP_EN
    mis_s = |(bus.redirect_addr_i & ALIGN_MASK);
`else
    mis_s = 1'b0;
`endif
    if (mis_s) begin
      target_s = TRAP_VEC;
    end else begin
      target_s = bus.redirect_addr_i;
    end
  end

  // Next-state logic. Priority is redirect > halt > stall > sequential.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d   = 1'b0;
`endif
    case (state_q)
      ST_BOOT: begin
        pc_d    = RESET_VEC;
        valid_d = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.redirect_i) begin
          pc_d    = target_s;
          valid_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
          misalign_d = mis_s;
`endif
        end else if (bus.halt_i) begin
          state_d = ST_HALT;
          valid_d = 1'b0;
        end else if (bus.stall_i) begin
          if (bus.flush_i) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end else begin
          pc_d         = pc_inc_s;
          valid_d      = ~bus.flush_i;
          ifid_pc_d    = pc_q;
          ifid_pc4_d   = pc_inc_s;
          ifid_instr_d = bus.imem_data_i;
        end
      end
      ST_HALT: begin
        // Only a redirect leaves HALT. Stall and flush are ignored here.
        if (bus.redirect_i) begin
          pc_d    = target_s;
          valid_d = 1'b0;
          state_d = ST_RUN;
`ifdef PC_MISALIGN_TRAP_EN
          misalign_d = mis_s;
`endif
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VEC;
        valid_d = 1'b0;
      end
    endcase
    halted_d = (state_d == ST_HALT);
  end

  // State, PC and IF/ID registers. All outputs come directly from these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VEC;
      valid_q      <= 1'b0;
      ifid_pc_q    <= {ADDR_W{1'b0}};
      ifid_pc4_q   <= {ADDR_W{1'b0}};
      ifid_instr_q <= 32'h0;
      halted_q     <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      halted_q     <= halted_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign bus.imem_addr_o  = pc_q;
  assign bus.ifid_valid_o = valid_q;
  assign bus.ifid_pc_o    = ifid_pc_q;
  assign bus.ifid_pc4_o   = ifid_pc4_q;
  assign bus.ifid_instr_o = ifid_instr_q;
  assign bus.halted_o     = halted_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.misalign_o   = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Testbench for pc_fetch_stage. There is a 32-bit instance for the main
// sequence and an 8-bit instance for the wrap case.
// Stimulus tasks push the expected post-edge state into a queue. Monitors
// pop an entry and compare it after each rising edge, and also right after
// an asynchronous reset assertion.
module tb_pc_fetch_stage;

  localparam logic [31:0] K = 32'hA5A5_5A5A;
  localparam logic [31:0] M32 = 32'hFFFF_FFFF;
  localparam logic [31:0] M8  = 32'h0000_00FF;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_PC   = 32'h80;
  localparam logic        MIS_FLAG = 1'b1;
`else
  localparam logic [31:0] MIS_PC   = 32'h42;
  localparam logic        MIS_FLAG = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        halted;
    logic        mis;
    logic        chk_fields;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst8_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic done8    = 1'b0;
  exp_t q32[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  pc_fetch_stage_if #(.ADDR_W(32)) bus32 ();
  pc_fetch_stage_if #(.ADDR_W(8))  bus8 ();

  pc_fetch_stage #(.ADDR_W(32), .RESET_VEC(32'h0), .INSTR_BYTES(4), .TRAP_VEC(32'h80))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus32));
  pc_fetch_stage #(.ADDR_W(8), .RESET_VEC(8'h0), .INSTR_BYTES(4), .TRAP_VEC(8'h80))
    dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));

  // The instruction memory returns a recognisable function of the address.
  assign bus32.imem_data_i = bus32.imem_addr_o ^ K;
  assign bus8.imem_data_i  = {24'h0, bus8.imem_addr_o} ^ K;

  function automatic exp_t mk(string n, logic [31:0] a, logic v, logic [31:0] pc,
                              logic h, logic mis, logic [31:0] m);
    exp_t e;
    e.name = n; e.addr = a; e.valid = v; e.pc = pc;
    e.pc4 = (pc + 32'd4) & m; e.instr = pc ^ K;
    e.halted = h; e.mis = mis; e.chk_fields = v;
    return e;
  endfunction

  function automatic exp_t mk_rst(string n);
    exp_t e;
    e.name = n; e.addr = 32'h0; e.valid = 1'b0; e.pc = 32'h0; e.pc4 = 32'h0;
    e.instr = 32'h0; e.halted = 1'b0; e.mis = 1'b0; e.chk_fields = 1'b1;
    return e;
  endfunction

  task automatic compare(input exp_t e, input logic [31:0] a, input logic v,
                         input logic [31:0] pc, input logic [31:0] pc4,
                         input logic [31:0] ins, input logic h, input logic mis);
    logic ok;
    ok = (a === e.addr) && (v === e.valid) && (h === e.halted) && (mis === e.mis);
    if (e.chk_fields) begin
      ok = ok && (pc === e.pc) && (pc4 === e.pc4) && (ins === e.instr);
    end else begin
      ok = ok;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got addr=%h valid=%b pc=%h pc4=%h instr=%h halted=%b mis=%b; want addr=%h valid=%b pc=%h pc4=%h instr=%h halted=%b mis=%b (fields checked=%b)",
               e.name, a, v, pc, pc4, ins, h, mis,
               e.addr, e.valid, e.pc, e.pc4, e.instr, e.halted, e.mis, e.chk_fields);
    end
  endtask

  task automatic check32(input exp_t e);
    logic mis;
`ifdef PC_MISALIGN_TRAP_EN
    mis = bus32.misalign_o;
`else
    mis = 1'b0;
`endif
    compare(e, bus32.imem_addr_o, bus32.ifid_valid_o, bus32.ifid_pc_o, bus32.ifid_pc4_o,
            bus32.ifid_instr_o, bus32.halted_o, mis);
  endtask

  task automatic check8(input exp_t e);
    logic mis;
`ifdef PC_MISALIGN_TRAP_EN
    mis = bus8.misalign_o;
`else
    mis = 1'b0;
`endif
    compare(e, {24'h0, bus8.imem_addr_o}, bus8.ifid_valid_o, {24'h0, bus8.ifid_pc_o},
            {24'h0, bus8.ifid_pc4_o}, bus8.ifid_instr_o, bus8.halted_o, mis);
  endtask

  // Monitor: after every rising edge, compare the 32-bit DUT with the next entry.
  always @(posedge clk) begin : mon32
    exp_t e;
    #2;
    if (q32.size() > 0) begin
      e = q32.pop_front();
      check32(e);
    end
  end

  // Monitor: reset must act on the outputs without waiting for a clock edge.
  always @(negedge rst_n) begin : mon32_rst
    exp_t e;
    #1;
    if (q32.size() > 0) begin
      e = q32.pop_front();
      check32(e);
    end
  end

  // Monitor for the 8-bit instance.
  always @(posedge clk) begin : mon8
    exp_t e;
    #2;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      check8(e);
    end
  end

  task automatic step32(input logic st, input logic fl, input logic rd,
                        input logic [31:0] ra, input logic ht, input exp_t e);
    @(negedge clk);
    bus32.stall_i = st; bus32.flush_i = fl; bus32.redirect_i = rd;
    bus32.redirect_addr_i = ra; bus32.halt_i = ht;
    q32.push_back(e);
  endtask

  task automatic release32(input exp_t e);
    @(negedge clk);
    bus32.stall_i = 1'b0; bus32.flush_i = 1'b0; bus32.redirect_i = 1'b0;
    bus32.redirect_addr_i = 32'h0; bus32.halt_i = 1'b0;
    rst_n = 1'b1;
    q32.push_back(e);
  endtask

  task automatic step8(input logic rd, input logic [7:0] ra, input exp_t e);
    @(negedge clk);
    bus8.redirect_i = rd; bus8.redirect_addr_i = ra;
    q8.push_back(e);
  endtask

  // Stimulus for the 8-bit instance: redirect to 0xFC, then watch the wrap.
  initial begin : stim8
    rst8_n = 1'b0;
    bus8.stall_i = 1'b0; bus8.flush_i = 1'b0; bus8.redirect_i = 1'b0;
    bus8.redirect_addr_i = 8'h0; bus8.halt_i = 1'b0;
    step8(1'b0, 8'h00, mk_rst("w8_reset"));
    @(negedge clk);
    rst8_n = 1'b1;
    q8.push_back(mk("w8_boot", 32'h00, 1'b0, 32'h0, 1'b0, 1'b0, M8));
    step8(1'b1, 8'hFC, mk("w8_redir_fc", 32'hFC, 1'b0, 32'h0, 1'b0, 1'b0, M8));
    step8(1'b0, 8'h00, mk("w8_wrap", 32'h00, 1'b1, 32'hFC, 1'b0, 1'b0, M8));
    step8(1'b0, 8'h00, mk("w8_after_wrap", 32'h04, 1'b1, 32'h00, 1'b0, 1'b0, M8));
    @(negedge clk);
    done8 = 1'b1;
  end

  // Main stimulus for the 32-bit instance.
  initial begin : stim32
    rst_n = 1'b0;
    bus32.stall_i = 1'b0; bus32.flush_i = 1'b0; bus32.redirect_i = 1'b0;
    bus32.redirect_addr_i = 32'h0; bus32.halt_i = 1'b0;
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mk_rst("reset"));
    release32(mk("boot", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mk("run1", 32'h4, 1'b1, 32'h0, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mk("run2", 32'h8, 1'b1, 32'h4, 1'b0, 1'b0, M32));
    step32(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, mk("stall1", 32'h8, 1'b1, 32'h4, 1'b0, 1'b0, M32));
    step32(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, mk("stall2", 32'h8, 1'b1, 32'h4, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mk("unstall", 32'hC, 1'b1, 32'h8, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mk("run3", 32'h10, 1'b1, 32'hC, 1'b0, 1'b0, M32));
    step32(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, mk("redir_stall", 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mk("after_redir", 32'h44, 1'b1, 32'h40, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, mk("flush", 32'h48, 1'b0, 32'h0, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mk("after_flush", 32'h4C, 1'b1, 32'h48, 1'b0, 1'b0, M32));
    step32(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, mk("stall_flush", 32'h4C, 1'b0, 32'h0, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mk("after_sf", 32'h50, 1'b1, 32'h4C, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b1, 32'h14, 1'b0, mk("redir_20", 32'h14, 1'b0, 32'h0, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, mk("halt", 32'h14, 1'b0, 32'h0, 1'b1, 1'b0, M32));
    for (int i = 0; i < 9; i++) begin
      logic [31:0] iv;
      iv = i;
      step32(iv[0], ~iv[0], 1'b0, 32'h0, iv[1],
             mk("halt_hold", 32'h14, 1'b0, 32'h0, 1'b1, 1'b0, M32));
    end
    step32(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, mk("unhalt", 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mk("after_unhalt", 32'h104, 1'b1, 32'h100, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, mk("redir_over_halt", 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mk("after_roh", 32'h204, 1'b1, 32'h200, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b1, 32'h42, 1'b0, mk("redir_misaligned", MIS_PC, 1'b0, 32'h0, 1'b0, MIS_FLAG, M32));
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mk("after_misaligned", MIS_PC + 32'd4, 1'b1, MIS_PC, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, mk("halt2", MIS_PC + 32'd4, 1'b0, 32'h0, 1'b1, 1'b0, M32));
    // Reset asserted mid-halt, between clock edges, while redirect and stall are active.
    @(negedge clk);
    bus32.stall_i = 1'b1; bus32.flush_i = 1'b1; bus32.redirect_i = 1'b1;
    bus32.redirect_addr_i = 32'h300; bus32.halt_i = 1'b1;
    q32.push_back(mk_rst("async_reset"));
    rst_n = 1'b0;
    step32(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, mk_rst("reset_hold"));
    release32(mk("reboot", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, M32));
    step32(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mk("rerun", 32'h4, 1'b1, 32'h0, 1'b0, 1'b0, M32));

    // Bounded wait for the 8-bit sequence, then let the monitors drain.
    for (int i = 0; i < 100 && !done8; i++) begin
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (!done8 || q32.size() != 0 || q8.size() != 0) begin
      n_fail++;
      $display("FAIL drain: done8=%b q32=%0d q8=%0d; want done8=1 q32=0 q8=0",
               done8, q32.size(), q8.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
